rvfi_trace_fifo: RTL

// Downstream consumer of the core's RVFI retirement port, alongside the simulation tracer.

---
 rtl/rvfi_trace_fifo_if.sv | 22 ++
 rtl/rvfi_trace_fifo.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/rvfi_trace_fifo_if.sv
// Trace word stream between rvfi_trace_fifo and a trace sink.
// master drives valid/data/last, slave drives ready.
interface rvfi_trace_fifo_if;
    logic        valid;
    logic        ready;
    logic [31:0] data;
    logic        last;

    modport master (
        output valid,
        output data,
        output last,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  last,
        output ready
    );
endinterface

// File: rtl/rvfi_trace_fifo.sv
// Captures one 4-word record per RVFI retirement into a record FIFO and streams
// the words out over trace (valid/ready, last on word 3); also level and drop count.
module rvfi_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int SEQ_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   trace_en_i,
    input  logic                   flush_i,
    input  logic                   rvfi_valid,
    input  logic [31:0]            rvfi_pc_rdata,
    input  logic [31:0]            rvfi_insn,
    input  logic [4:0]             rvfi_rd_addr,
    input  logic [31:0]            rvfi_rd_wdata,
    input  logic [3:0]             rvfi_mem_rmask,
    input  logic [3:0]             rvfi_mem_wmask,
    rvfi_trace_fifo_if.master      trace,
    output logic [$clog2(DEPTH):0] fifo_level_o,
    output logic [15:0]            drop_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state;
    state_t           nxt_state;
    logic [3:0][31:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [LW-1:0]    level;
    logic [LW-1:0]    nxt_level;
    logic [1:0]       idx;
    logic [SEQ_W-1:0] seq;
    logic             lost;
    logic [15:0]      drops;
    logic             qual;
    logic             full;
    logic             push;
    logic             drop;
    logic             beat;
    logic             pop;
    logic [31:0]      w3;

    assign qual = rvfi_valid & trace_en_i;
    // Full is judged on the registered level, so a same-cycle pop frees nothing.
    assign full = (level == LW'(DEPTH));
    assign push = qual & ~full & ~flush_i;
    assign drop = qual & full & ~flush_i;
    assign beat = (state == SEND) & trace.ready & ~flush_i;
    assign pop  = beat & (idx == 2'd3);

    assign nxt_level = level + LW'(push) - LW'(pop);

    assign w3 = {seq[15:0], lost, 2'b00, rvfi_rd_addr,
                 rvfi_mem_wmask, rvfi_mem_rmask};

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wptr] <= {w3, rvfi_rd_wdata, rvfi_insn, rvfi_pc_rdata};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            idx   <= '0;
            seq   <= '0;
            lost  <= 1'b0;
            drops <= '0;
        end else begin
            if (qual) begin
                seq <= seq + 1'b1;
            end
            if (flush_i) begin
                wptr  <= '0;
                rptr  <= '0;
                level <= '0;
                idx   <= '0;
                lost  <= 1'b0;
            end else begin
                level <= nxt_level;
                if (push) begin
                    wptr <= wptr + 1'b1;
                end
                if (pop) begin
                    rptr <= rptr + 1'b1;
                end
                // idx wraps 3 -> 0 exactly when the record pops
                if (beat) begin
                    idx <= idx + 1'b1;
                end
                if (drop) begin
                    lost <= 1'b1;
                    if (drops != 16'hFFFF) begin
                        drops <= drops + 1'b1;
                    end
                end else if (push) begin
                    lost <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    // Looking at the post-update level lets a push raise valid on the very
    // next cycle and keeps back-to-back records gap-free.
    always_comb begin
        nxt_state = state;
        unique case (state)
            IDLE: if (!flush_i && nxt_level != '0) nxt_state = SEND;
            SEND: if (flush_i || nxt_level == '0) nxt_state = IDLE;
        endcase
    end

    always_comb begin
        trace.valid = 1'b0;
        trace.data  = '0;
        trace.last  = 1'b0;
        if (state == SEND) begin
            trace.valid = 1'b1;
            trace.data  = mem[rptr][idx];
            trace.last  = (idx == 2'd3);
        end
    end

    assign fifo_level_o = level;
    assign drop_cnt_o   = drops;

endmodule
